// File: rtl/avalon_arg_controller.sv
// Avalon-MM register block that launches one accelerator run, holds its arguments and captures results.
// Optional watchdog: define ARGCTL_TIMEOUT_EN to end a run after TIMEOUT_CYCLES without io_done.
module avalon_arg_controller #(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_ARG_INS    = 2,
  parameter int NUM_ARG_OUTS   = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [ADDR_WIDTH-1:0]              io_S_AVALON_address,
  input  logic                               io_S_AVALON_chipselect,
  input  logic                               io_S_AVALON_write,
  input  logic [DATA_WIDTH-1:0]              io_S_AVALON_writedata,
  input  logic                               io_S_AVALON_read,
  output logic [DATA_WIDTH-1:0]              io_S_AVALON_readdata,
  output logic                               io_enable,
  input  logic                               io_done,
  output logic [NUM_ARG_INS*DATA_WIDTH-1:0]  io_argIns,
  input  logic [NUM_ARG_OUTS*DATA_WIDTH-1:0] io_argOuts,
  output logic                               io_busy,
  output logic [1:0]                         debug_state
);

  // Bus handshake: there is no waitrequest, so every cycle with write=1 or
  // read=1 is one accepted transfer; read data appears exactly one cycle later.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ARGIN_BASE  = 2;
  localparam int ARGOUT_BASE = 2 + NUM_ARG_INS;
  localparam int CNT_ADDR    = 2 + NUM_ARG_INS + NUM_ARG_OUTS;

  state_t                state_q;
  state_t                state_d;
  logic                  latch_outs;
  logic                  done_q;
  logic                  timeout_q;
  logic                  timeout_hit;
  logic [DATA_WIDTH-1:0] cycle_cnt;
  logic [DATA_WIDTH-1:0] arg_in_q  [NUM_ARG_INS];
  logic [DATA_WIDTH-1:0] arg_out_q [NUM_ARG_OUTS];
  logic [DATA_WIDTH-1:0] rd_mux;

  logic cmd_wr;
  logic start;
  logic clear;
  logic unused_ok;

  assign unused_ok = &{1'b0, io_S_AVALON_chipselect};

  assign cmd_wr = io_S_AVALON_write && (io_S_AVALON_address == ADDR_WIDTH'(0));
  assign start  = cmd_wr && io_S_AVALON_writedata[0];
  assign clear  = cmd_wr && !io_S_AVALON_writedata[0];

`ifdef ARGCTL_TIMEOUT_EN
  assign timeout_hit = (state_q == RUN) && !io_done &&
                       (cycle_cnt >= DATA_WIDTH'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  // io_done takes priority over both the watchdog and an abort write.
  always_comb begin
    state_d    = state_q;
    latch_outs = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (io_done) begin
          state_d    = DONE;
          latch_outs = 1'b1;
        end else if (timeout_hit) begin
          state_d = DONE;
        end else if (clear) begin
          state_d = IDLE;
        end
      end
      DONE: if (clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_q    <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        done_q    <= 1'b0;
        cycle_cnt <= '0;
      end else if (state_q == RUN && state_d == DONE) begin
        done_q <= 1'b1;
      end else if (state_q == RUN && state_d == RUN && cycle_cnt != '1) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
    end
  end

`ifdef ARGCTL_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timeout_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_q = 1'b0;
`endif

  // Arguments are frozen while the accelerator is running.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ARG_INS; i++) arg_in_q[i] <= '0;
    end else if (io_S_AVALON_write && state_q != RUN) begin
      for (int i = 0; i < NUM_ARG_INS; i++) begin
        if (io_S_AVALON_address == ADDR_WIDTH'(ARGIN_BASE + i)) begin
          arg_in_q[i] <= io_S_AVALON_writedata;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ARG_OUTS; i++) arg_out_q[i] <= '0;
    end else if (latch_outs) begin
      for (int i = 0; i < NUM_ARG_OUTS; i++) begin
        arg_out_q[i] <= io_argOuts[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (io_S_AVALON_address == ADDR_WIDTH'(0)) begin
      rd_mux[0] = (state_q != IDLE);
    end else if (io_S_AVALON_address == ADDR_WIDTH'(1)) begin
      rd_mux[0] = done_q;
      rd_mux[1] = timeout_q;
      rd_mux[2] = (state_q == RUN);
    end else if (io_S_AVALON_address == ADDR_WIDTH'(CNT_ADDR)) begin
      rd_mux = cycle_cnt;
    end else begin
      for (int i = 0; i < NUM_ARG_INS; i++) begin
        if (io_S_AVALON_address == ADDR_WIDTH'(ARGIN_BASE + i)) rd_mux = arg_in_q[i];
      end
      for (int i = 0; i < NUM_ARG_OUTS; i++) begin
        if (io_S_AVALON_address == ADDR_WIDTH'(ARGOUT_BASE + i)) rd_mux = arg_out_q[i];
      end
    end
  end

  // Registered read uses pre-edge register values, so read-during-write sees old data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_S_AVALON_readdata <= '0;
    end else if (io_S_AVALON_read) begin
      io_S_AVALON_readdata <= rd_mux;
    end
  end

  for (genvar g = 0; g < NUM_ARG_INS; g++) begin : g_argins
    assign io_argIns[g*DATA_WIDTH +: DATA_WIDTH] = arg_in_q[g];
  end

  assign io_enable   = (state_q == RUN);
  assign io_busy     = (state_q == RUN);
  assign debug_state = state_q;

endmodule

// File: tb/tb_avalon_arg_controller.sv
// Directed bench for avalon_arg_controller: register map, run/abort/done sequencing and reset.
// Builds with or without ARGCTL_TIMEOUT_EN; the watchdog limit is set to 20 here.
module tb_avalon_arg_controller;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clock;
  logic          reset;
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write;
  logic [DW-1:0] writedata;
  logic          read;
  logic [DW-1:0] readdata;
  logic          enable;
  logic          done;
  logic [2*DW-1:0] arg_ins;
  logic [DW-1:0] arg_outs;
  logic          busy;
  logic [1:0]    debug_state;

  int n_checks = 0;
  int n_errors = 0;

  avalon_arg_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ARG_INS(2), .NUM_ARG_OUTS(1), .TIMEOUT_CYCLES(20)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io_S_AVALON_address(address),
    .io_S_AVALON_chipselect(chipselect),
    .io_S_AVALON_write(write),
    .io_S_AVALON_writedata(writedata),
    .io_S_AVALON_read(read),
    .io_S_AVALON_readdata(readdata),
    .io_enable(enable),
    .io_done(done),
    .io_argIns(arg_ins),
    .io_argOuts(arg_outs),
    .io_busy(busy),
    .debug_state(debug_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drivers: inputs change on the falling edge, outputs sampled 1ns after the rising edge
  task automatic bus_write(input int addr, input logic [DW-1:0] data);
    @(negedge clock);
    address = AW'(addr); writedata = data; write = 1'b1; chipselect = 1'b1;
    @(posedge clock); #1;
    write = 1'b0; chipselect = 1'b0;
  endtask

  task automatic bus_read(input int addr, output logic [DW-1:0] data);
    @(negedge clock);
    address = AW'(addr); read = 1'b1; chipselect = 1'b1;
    @(posedge clock); #1;
    read = 1'b0; chipselect = 1'b0;
    data = readdata;
  endtask

  task automatic read_check(input string tag, input int addr, input logic [DW-1:0] exp);
    logic [DW-1:0] d;
    bus_read(addr, d);
    check(tag, d, exp);
  endtask

  logic [DW-1:0] rd;

  initial begin
    reset = 1'b0; address = '0; chipselect = 1'b0; write = 1'b0;
    writedata = '0; read = 1'b0; done = 1'b0; arg_outs = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_enable", enable, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_argins", arg_ins, 64'h0);
    check("rst_readdata", readdata, 32'h0);
    check("rst_state", debug_state, 2'd0);
    @(negedge clock); reset = 1'b1;

    for (int a = 0; a <= 5; a++) read_check($sformatf("rst_read_%0d", a), a, 32'h0);

    // argIn writes, read latency, read-during-write, unmapped address
    bus_write(2, 32'h4);
    bus_write(3, 32'h7);
    check("argins_wr", arg_ins, {32'h7, 32'h4});
    read_check("read_arg0", 2, 32'h4);
    @(negedge clock);
    address = AW'(3); writedata = 32'h11; write = 1'b1; read = 1'b1;
    @(posedge clock); #1;
    write = 1'b0; read = 1'b0;
    check("rdw_old_value", readdata, 32'h7);
    read_check("rdw_new_value", 3, 32'h11);
    bus_write(9, 32'hDEAD);
    read_check("unmapped_read", 9, 32'h0);
    bus_write(4, 32'h5);
    read_check("argout_ro_idle", 4, 32'h0);

    // run 1: io_done 50 cycles after enable rises
    bus_write(0, 32'h1);
    check("run1_enable", enable, 1'b1);
    check("run1_busy", busy, 1'b1);
    repeat (50) @(posedge clock);
    #1;
    check("run1_enable_before_done", enable, 1'b1);
    done = 1'b1; arg_outs = 32'h2A;
    @(posedge clock); #1;
    done = 1'b0;
    check("run1_enable_fall", enable, 1'b0);
    check("run1_state", debug_state, 2'd2);
    read_check("run1_status", 1, 32'h1);
    read_check("run1_argout", 4, 32'h2A);
    read_check("run1_counter", 5, 32'd50);
    read_check("run1_cmd", 0, 32'h1);
    bus_write(0, 32'h1);
    read_check("done_restart_ignored", 5, 32'd50);

    // clear to IDLE: done is sticky until the next start
    bus_write(0, 32'h0);
    check("clear_state", debug_state, 2'd0);
    read_check("clear_status", 1, 32'h1);
    read_check("clear_cmd", 0, 32'h0);

    // run 2: RO and argIn writes ignored, then abort
    bus_write(0, 32'h1);
    read_check("run2_status", 1, 32'h4);
    read_check("run2_cmd", 0, 32'h1);
    bus_write(2, 32'h9);
    bus_write(4, 32'h5);
    read_check("run2_arg0_frozen", 2, 32'h4);
    check("run2_argins_frozen", arg_ins, {32'h11, 32'h4});
    read_check("run2_argout_ro", 4, 32'h2A);
    arg_outs = 32'h77;
    bus_write(0, 32'h0);
    check("abort_enable", enable, 1'b0);
    check("abort_state", debug_state, 2'd0);
    read_check("abort_status", 1, 32'h0);
    read_check("abort_argout", 4, 32'h2A);
    done = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    done = 1'b0;
    check("idle_done_ignored", debug_state, 2'd0);

    // run 3: io_done together with an abort write -> io_done wins
    bus_write(0, 32'h1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    address = AW'(0); writedata = 32'h0; write = 1'b1; done = 1'b1; arg_outs = 32'h55;
    @(posedge clock); #1;
    write = 1'b0; done = 1'b0;
    check("race_state", debug_state, 2'd2);
    check("race_enable", enable, 1'b0);
    read_check("race_status", 1, 32'h1);
    read_check("race_argout", 4, 32'h55);
    bus_write(2, 32'h33);
    read_check("done_argin_wr", 2, 32'h33);

    // run 4: asynchronous reset mid-run
    bus_write(0, 32'h0);
    bus_write(0, 32'h1);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("arst_enable", enable, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_argins", arg_ins, 64'h0);
    check("arst_state", debug_state, 2'd0);
    @(negedge clock); reset = 1'b1;
    read_check("arst_arg0", 2, 32'h0);
    read_check("arst_argout", 4, 32'h0);
    read_check("arst_status", 1, 32'h0);
    read_check("arst_counter", 5, 32'h0);

    // run 5: no io_done at all
    bus_write(0, 32'h1);
`ifdef ARGCTL_TIMEOUT_EN
    repeat (25) @(posedge clock);
    #1;
    check("timeout_enable", enable, 1'b0);
    read_check("timeout_status", 1, 32'h3);
    read_check("timeout_counter", 5, 32'd20);
    read_check("timeout_argout", 4, 32'h0);
`else
    repeat (1000) @(posedge clock);
    #1;
    check("no_timeout_enable", enable, 1'b1);
    read_check("no_timeout_status", 1, 32'h4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/avalon_arg_controller.md
Name: avalon_arg_controller

Overview:
- Avalon-MM slave register block that runs one accelerator between the host and the compute fabric.
- Holds the argIn registers, command register and status register. Captures argOuts and a run-cycle count.
- Drives the accelerator enable and detects completion. Sits directly under Top, between the io_S_AVALON_* port and the accelerator datapath.

Parameters:
ADDR_WIDTH, 9, Avalon word-address width
DATA_WIDTH, 32, register and bus width
NUM_ARG_INS, 2, number of host-writable argIn registers
NUM_ARG_OUTS, 1, number of accelerator-written argOut registers
TIMEOUT_CYCLES, 1000000, watchdog limit (used only with ARGCTL_TIMEOUT_EN)

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-low reset
io_S_AVALON_address  in  ADDR_WIDTH  word address
io_S_AVALON_chipselect  in  1  accepted; not used for qualification (read/write alone qualify)
io_S_AVALON_write  in  1  write strobe
io_S_AVALON_writedata  in  DATA_WIDTH  write data
io_S_AVALON_read  in  1  read strobe
io_S_AVALON_readdata  out  DATA_WIDTH  read data, readLatency 1
io_enable  out  1  accelerator run enable
io_done  in  1  accelerator completion pulse/level
io_argIns  out  NUM_ARG_INS*DATA_WIDTH  flattened argIn registers, index 0 at LSBs
io_argOuts  in  NUM_ARG_OUTS*DATA_WIDTH  accelerator argOut values
io_busy  out  1  high while state is RUN

Behaviour:
- Register map (word addresses), with NI = NUM_ARG_INS and NO = NUM_ARG_OUTS:
  - 0: command (RW). Bit0 = enable; bits 31:1 read 0.
  - 1: status (RO). Bit0 = done; bit1 = timeout; bit2 = busy.
  - 2 .. 2+NI-1: argIns (RW).
  - 2+NI .. 2+NI+NO-1: argOuts (RO).
  - 2+NI+NO: cycle counter (RO).
  - Any other address reads 0; writes to it are ignored.
- Reset (reset=0, asynchronous):
  - All registers and readdata clear to 0.
  - io_enable=0, io_busy=0, state IDLE.
- Write access:
  - Takes effect on the clock edge with io_S_AVALON_write=1.
  - Writes to RO addresses are dropped.
  - argIn writes are ignored while state is RUN, so arguments stay stable during a run.
- Read access:
  - io_S_AVALON_readdata is registered and valid on the cycle after io_S_AVALON_read=1.
  - Holds its last value when read=0.
  - If read and write hit the same address in one cycle, the read returns the pre-write value.
- FSM states IDLE, RUN, DONE:
  - IDLE -> RUN: write to addr 0 with bit0=1. Clears done, timeout and the cycle counter. io_enable rises on the next cycle.
  - RUN: io_enable=1. The cycle counter increments every cycle and saturates at 2^DATA_WIDTH-1.
  - RUN -> DONE: first cycle io_done=1 is sampled.
    - io_argOuts are latched into the argOut registers on that edge.
    - status.done=1; io_enable falls on the next cycle.
    - The counter holds.
  - RUN -> IDLE (abort): write to addr 0 with bit0=0. io_enable=0, done stays 0, argOuts are not updated.
  - DONE -> IDLE: write to addr 0 with bit0=0. done stays set until the next start.
  - A write of bit0=1 in RUN or DONE is ignored. A rerun requires clearing first.
  - io_done outside RUN is ignored.
- Simultaneous io_done and abort write in the same cycle: io_done wins (DONE, argOuts latched). The abort write is dropped.
- Command register bit0 reads back 1 in RUN and DONE, and 0 in IDLE.

Optional Feature:
- Macro: ARGCTL_TIMEOUT_EN.
- When defined:
  - In RUN, when the cycle counter reaches TIMEOUT_CYCLES without io_done, the block goes to DONE.
  - status.timeout=1 and status.done=1; argOuts are not latched.
  - io_enable drops on the next cycle.
- When undefined:
  - No watchdog logic is built; RUN waits forever.
  - status bit1 reads 0.

Test Plan:
- Reset, then read every address 0..2+NI+NO -> all readdata 0, io_enable=0, io_argIns=0.
- Write addr2=0x4, addr3=0x7 -> io_argIns={0x7,0x4}. Read addr2 -> 0x4 one cycle after read.
- Write addr0=1. Accelerator asserts io_done 50 cycles after io_enable rises, with io_argOuts=0x2A.
  -> status=0x1, addr4=0x2A, counter=50.
  -> io_enable low one cycle after io_done.
- During RUN, write addr2=0x9 and addr4=0x5 -> both ignored (addr2 stays 0x4). Then write addr0=0 -> IDLE, done=0, addr4 unchanged.
- In RUN, drive io_done and an addr0=0 write in the same cycle -> state DONE, argOuts latched, status.done=1. Assert reset mid-RUN -> io_enable=0 immediately, all registers 0.
- With ARGCTL_TIMEOUT_EN and TIMEOUT_CYCLES=20, start and never assert io_done -> after 20 cycles status=0x3, io_enable=0. Without the macro, io_enable is still 1 at cycle 1000.
